// File: rtl/channel_fir_awgn_pkg.sv
// ============================================================================
// channel_pkg : shared constants and fixed-point helpers for the channel model
//               and the receiver equaliser.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package channel_pkg;

    localparam int          CH_LAT         = 4;
    localparam int          COEF_ONE       = 1 << 14;
    localparam logic [31:0] SEED_I_DEFAULT = 32'h1234_5678;
    localparam logic [31:0] SEED_Q_DEFAULT = 32'h8765_4321;

    function automatic int coef_one(input int cw);
        return 1 << (cw - 2);
    endfunction

    // Sized so that NTAPS full-scale complex products cannot overflow.
    function automatic int acc_width(input int dw, input int cw, input int nt);
        return dw + cw + 1 + $clog2(nt);
    endfunction

    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                       input int sh);
        return (x + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x,
                                                     input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        return x;
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] x, input int w);
        return (x > ((64'sd1 <<< (w - 1)) - 64'sd1)) || (x < -(64'sd1 <<< (w - 1)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/channel_fir_awgn_noise_gen_xorshift.sv
// ============================================================================
// noise_gen_xorshift : xorshift32 generator, raw output is the sum of the four
//                      signed bytes of the current state.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module noise_gen_xorshift #(
    parameter logic [31:0] SEED = 32'h1234_5678
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic signed [9:0] raw
);

    logic [31:0] r_state;
    logic [31:0] w_s1;
    logic [31:0] w_s2;
    logic [31:0] w_next;

    always_comb begin
        w_s1   = r_state ^ (r_state << 13);
        w_s2   = w_s1 ^ (w_s1 >> 17);
        w_next = w_s2 ^ (w_s2 << 5);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= SEED;
        else if (step)
            r_state <= w_next;
    end

    assign raw = 10'($signed(r_state[7:0]))   + 10'($signed(r_state[15:8]))
               + 10'($signed(r_state[23:16])) + 10'($signed(r_state[31:24]));

endmodule

`default_nettype wire

// File: rtl/channel_fir_awgn.sv
// ============================================================================
// channel_fir_awgn : complex NTAPS FIR multipath channel with scaled xorshift
//                    noise, saturation reporting and double-buffered taps.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module channel_fir_awgn
    import channel_pkg::*;
#(
    parameter int          DWIDTH    = 16,
    parameter int          CWIDTH    = 16,
    parameter int          NTAPS     = 4,
    parameter int          SNR_WIDTH = 11,
    parameter int          NSHIFT    = 4,
    parameter logic [31:0] SEED_I    = SEED_I_DEFAULT,
    parameter logic [31:0] SEED_Q    = SEED_Q_DEFAULT,
    localparam int         AW        = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] In_I,
    input  logic signed [DWIDTH-1:0] In_Q,
    input  logic [SNR_WIDTH-1:0]     sigma_scale,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [CWIDTH-1:0] coef_I,
    input  logic signed [CWIDTH-1:0] coef_Q,
    input  logic                     coef_commit,
    input  logic                     sat_clr,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] Out_I,
    output logic signed [DWIDTH-1:0] Out_Q,
    output logic                     sat_flag,
    output logic [15:0]              sat_count
);

    localparam int c_mw   = DWIDTH + CWIDTH;
    localparam int c_pw   = c_mw + 1;
    localparam int c_accw = acc_width(DWIDTH, CWIDTH, NTAPS);
    localparam int c_npw  = 10 + NSHIFT + SNR_WIDTH + 1;
    localparam int c_nw   = c_npw - 10;
    localparam logic signed [CWIDTH-1:0] c_one = CWIDTH'(coef_one(CWIDTH));

    logic signed [CWIDTH-1:0] r_sh_i [NTAPS];
    logic signed [CWIDTH-1:0] r_sh_q [NTAPS];
    logic signed [CWIDTH-1:0] r_ac_i [NTAPS];
    logic signed [CWIDTH-1:0] r_ac_q [NTAPS];
    logic signed [DWIDTH-1:0] r_x_i  [NTAPS];
    logic signed [DWIDTH-1:0] r_x_q  [NTAPS];
    logic signed [c_mw-1:0]   w_m_ii [NTAPS];
    logic signed [c_mw-1:0]   w_m_qq [NTAPS];
    logic signed [c_mw-1:0]   w_m_iq [NTAPS];
    logic signed [c_mw-1:0]   w_m_qi [NTAPS];
    logic signed [c_pw-1:0]   r_p_i  [NTAPS];
    logic signed [c_pw-1:0]   r_p_q  [NTAPS];
    logic signed [c_accw-1:0] w_acc_i, w_acc_q, r_acc_i, r_acc_q;
    logic [SNR_WIDTH-1:0]     r_sigma;
    logic signed [9:0]        w_raw_i, w_raw_q;
    logic signed [c_npw-1:0]  w_sig;
    logic signed [c_npw-1:0]  r_np_i, r_np_q;
    logic signed [c_nw-1:0]   r_n_i, r_n_q;
    logic signed [63:0]       w_sum_i, w_sum_q;
    logic                     w_sat;
    logic                     r_v1, r_v2, r_v3;

    noise_gen_xorshift #(.SEED(SEED_I)) u_noise_i (
        .clk(clk), .rst(rst), .step(in_valid), .raw(w_raw_i)
    );
    noise_gen_xorshift #(.SEED(SEED_Q)) u_noise_q (
        .clk(clk), .rst(rst), .step(in_valid), .raw(w_raw_q)
    );

    // A write in the commit cycle goes straight into the active bank too.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NTAPS; k++) begin
            if (rst) begin
                r_sh_i[k] <= (k == 0) ? c_one : '0;
                r_sh_q[k] <= '0;
                r_ac_i[k] <= (k == 0) ? c_one : '0;
                r_ac_q[k] <= '0;
            end else begin
                if (coef_we && coef_addr == AW'(k)) begin
                    r_sh_i[k] <= coef_I;
                    r_sh_q[k] <= coef_Q;
                end
                if (coef_commit) begin
                    r_ac_i[k] <= (coef_we && coef_addr == AW'(k)) ? coef_I : r_sh_i[k];
                    r_ac_q[k] <= (coef_we && coef_addr == AW'(k)) ? coef_Q : r_sh_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_x_i[k] <= '0;
                r_x_q[k] <= '0;
            end
        end else if (in_valid) begin
            r_x_i[0] <= In_I;
            r_x_q[0] <= In_Q;
            for (int k = 1; k < NTAPS; k++) begin
                r_x_i[k] <= r_x_i[k-1];
                r_x_q[k] <= r_x_q[k-1];
            end
        end
    end

    always_comb begin
        w_acc_i = '0;
        w_acc_q = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_m_ii[k] = c_mw'(r_ac_i[k]) * c_mw'(r_x_i[k]);
            w_m_qq[k] = c_mw'(r_ac_q[k]) * c_mw'(r_x_q[k]);
            w_m_iq[k] = c_mw'(r_ac_i[k]) * c_mw'(r_x_q[k]);
            w_m_qi[k] = c_mw'(r_ac_q[k]) * c_mw'(r_x_i[k]);
            w_acc_i   = w_acc_i + c_accw'(r_p_i[k]);
            w_acc_q   = w_acc_q + c_accw'(r_p_q[k]);
        end
    end

    assign w_sig = c_npw'($signed({1'b0, r_sigma}));

    // The stages free-run; only the valid chain decides what reaches the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_sigma <= '0;
        end else begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (in_valid)
                r_sigma <= sigma_scale;
        end
        for (int k = 0; k < NTAPS; k++) begin
            r_p_i[k] <= c_pw'(w_m_ii[k]) - c_pw'(w_m_qq[k]);
            r_p_q[k] <= c_pw'(w_m_iq[k]) + c_pw'(w_m_qi[k]);
        end
        r_acc_i <= w_acc_i;
        r_acc_q <= w_acc_q;
        r_np_i  <= (c_npw'(w_raw_i) <<< NSHIFT) * w_sig;
        r_np_q  <= (c_npw'(w_raw_q) <<< NSHIFT) * w_sig;
        r_n_i   <= c_nw'((r_np_i + c_npw'(512)) >>> 10);
        r_n_q   <= c_nw'((r_np_q + c_npw'(512)) >>> 10);
    end

    always_comb begin
        w_sum_i = round_shift(64'(r_acc_i), CWIDTH - 2) + 64'(r_n_i);
        w_sum_q = round_shift(64'(r_acc_q), CWIDTH - 2) + 64'(r_n_q);
        w_sat   = sat_hit(w_sum_i, DWIDTH) || sat_hit(w_sum_q, DWIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Out_I     <= '0;
            Out_Q     <= '0;
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else begin
            out_valid <= r_v3;
            sat_flag  <= r_v3 && w_sat;
            if (r_v3) begin
                Out_I <= DWIDTH'(sat_clamp(w_sum_i, DWIDTH));
                Out_Q <= DWIDTH'(sat_clamp(w_sum_q, DWIDTH));
            end
            if (sat_clr)
                sat_count <= '0;
            else if (r_v3 && w_sat && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_channel_fir_awgn.sv
// ============================================================================
// tb_channel_fir_awgn : directed tap table plus randomized traffic against an
//                       arithmetic channel model.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_channel_fir_awgn;

    logic               clk = 1'b0;
    logic               rst, in_valid, coef_we, coef_commit, sat_clr;
    logic signed [15:0] In_I, In_Q, coef_I, coef_Q;
    logic [10:0]        sigma_scale;
    logic [1:0]         coef_addr;
    logic               out_valid, sat_flag;
    logic signed [15:0] Out_I, Out_Q;
    logic [15:0]        sat_count;

    channel_fir_awgn u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .In_I(In_I), .In_Q(In_Q),
        .sigma_scale(sigma_scale), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_I(coef_I), .coef_Q(coef_Q), .coef_commit(coef_commit),
        .sat_clr(sat_clr), .out_valid(out_valid), .Out_I(Out_I), .Out_Q(Out_Q),
        .sat_flag(sat_flag), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct { int i; int q; bit s; } exp_t;
    typedef struct { int h0i, h0q, h1i, h1q, xi, xq, ei, eq; bit es; } vec_t;

    int          n_vec = 0, n_bad = 0;
    int          sh_i[4], sh_q[4], ac_i[4], ac_q[4], mx_i[4], mx_q[4];
    int unsigned ns_i, ns_q;
    exp_t        eq[$];
    bit [3:0]    vh;
    int          cnt, last_i, last_q;
    bit          d_v, d_we, d_commit, d_clr, d_rs;
    int          d_xi, d_xq, d_sig, d_addr, d_ci, d_cq;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input real act, input real lo, input real hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %f expected in [%f,%f]", name, act, lo, hi);
        end
    endtask

    function automatic int unsigned xs(input int unsigned s);
        int unsigned t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        return t ^ (t << 5);
    endfunction

    function automatic int byte_sum(input int unsigned s);
        int r = 0;
        for (int b = 0; b < 4; b++) begin
            logic signed [7:0] t;
            t = s[8*b +: 8];
            r += t;
        end
        return r;
    endfunction

    function automatic int clamp16(input longint v);
        return (v > 32767) ? 32767 : (v < -32768) ? -32768 : int'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            sh_i[k] = (k == 0) ? 16384 : 0; sh_q[k] = 0;
            ac_i[k] = (k == 0) ? 16384 : 0; ac_q[k] = 0;
            mx_i[k] = 0; mx_q[k] = 0;
        end
        ns_i = 32'h1234_5678; ns_q = 32'h8765_4321;
        eq.delete(); vh = '0; cnt = 0; last_i = 0; last_q = 0;
    endtask

    task automatic accept();
        longint ai = 0, aq = 0, ni, nq, yi, yq;
        exp_t   e;
        for (int k = 3; k > 0; k--) begin mx_i[k] = mx_i[k-1]; mx_q[k] = mx_q[k-1]; end
        mx_i[0] = d_xi; mx_q[0] = d_xq;
        ns_i = xs(ns_i); ns_q = xs(ns_q);
        for (int k = 0; k < 4; k++) begin
            ai += longint'(ac_i[k]) * mx_i[k] - longint'(ac_q[k]) * mx_q[k];
            aq += longint'(ac_i[k]) * mx_q[k] + longint'(ac_q[k]) * mx_i[k];
        end
        ni = (longint'(byte_sum(ns_i)) * 16 * d_sig + 512) >>> 10;
        nq = (longint'(byte_sum(ns_q)) * 16 * d_sig + 512) >>> 10;
        yi = ((ai + 8192) >>> 14) + ni;
        yq = ((aq + 8192) >>> 14) + nq;
        e.i = clamp16(yi); e.q = clamp16(yq);
        e.s = (yi != e.i) || (yq != e.q);
        eq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        bit   ov;
        rst = d_rs; in_valid = d_v; In_I = 16'(d_xi); In_Q = 16'(d_xq);
        sigma_scale = 11'(d_sig); coef_we = d_we; coef_addr = 2'(d_addr);
        coef_I = 16'(d_ci); coef_Q = 16'(d_cq); coef_commit = d_commit; sat_clr = d_clr;
        @(posedge clk);
        e = '{0, 0, 1'b0};
        ov = 1'b0;
        if (d_rs) begin
            model_reset();
        end else begin
            if (d_we) begin sh_i[d_addr] = d_ci; sh_q[d_addr] = d_cq; end
            if (d_commit) begin ac_i = sh_i; ac_q = sh_q; end
            if (d_v) accept();
            vh = {vh[2:0], d_v};
            ov = vh[3];
            if (ov) begin
                if (eq.size() > 0) e = eq.pop_front();
                last_i = e.i; last_q = e.q;
            end
            if (d_clr) cnt = 0;
            else if (ov && e.s && cnt < 16'hFFFF) cnt++;
        end
        #1;
        chk("out_valid", out_valid, ov);
        if (ov) begin
            chk("out_i", Out_I, e.i);
            chk("out_q", Out_Q, e.q);
            chk("sat_flag", sat_flag, e.s);
        end else begin
            chk("idle_sat_flag", sat_flag, 0);
            chk("hold_i", Out_I, last_i);
            chk("hold_q", Out_Q, last_q);
        end
        chk("sat_count", sat_count, cnt);
        d_we = 0; d_commit = 0; d_clr = 0; d_rs = 0;
    endtask

    task automatic set_tap(input int a, input int ci, input int cq, input bit commit);
        d_v = 0; d_we = 1; d_addr = a; d_ci = ci; d_cq = cq; d_commit = commit;
        tick();
    endtask

    vec_t tbl[8];
    real  s_i, s_q, ss_i, ss_q, m_i, m_q;
    int   n_s;

    initial begin
        tbl[0] = '{16384, 0, 0, 0, 1000, 0, 1000, 0, 1'b0};
        tbl[1] = '{16384, 0, 8192, 0, 10000, 0, 15000, 0, 1'b0};
        tbl[2] = '{0, 16384, 0, 0, 1000, 0, 0, 1000, 1'b0};
        tbl[3] = '{16384, 0, 16384, 0, 30000, 0, 32767, 0, 1'b1};
        tbl[4] = '{16384, 0, 16384, 0, -30000, 0, -32768, 0, 1'b1};
        tbl[5] = '{16384, 16384, 0, 0, 1000, 2000, -1000, 3000, 1'b0};
        tbl[6] = '{-16384, 0, 0, 0, -32768, -32768, 32767, 32767, 1'b1};
        tbl[7] = '{8192, 0, 0, 0, 3, -3, 2, -1, 1'b0};
        {d_v, d_we, d_commit, d_clr} = '0;
        {d_xi, d_xq, d_sig, d_addr, d_ci, d_cq} = '0;
        model_reset();

        // Reset then impulse through identity taps with no noise.
        d_rs = 1; tick();
        d_v = 1; d_xi = 1000; tick();
        d_xi = 0;
        for (int t = 0; t < 6; t++) tick();

        foreach (tbl[n]) begin
            d_rs = 1; d_v = 0; tick();
            set_tap(0, tbl[n].h0i, tbl[n].h0q, 1'b0);
            set_tap(1, tbl[n].h1i, tbl[n].h1q, 1'b1);
            d_we = 0; d_v = 1; d_sig = 0; d_xi = tbl[n].xi; d_xq = tbl[n].xq;
            for (int t = 0; t < 8; t++) tick();
            chk("tbl_out_i", Out_I, tbl[n].ei);
            chk("tbl_out_q", Out_Q, tbl[n].eq);
            chk("tbl_sat", sat_flag, tbl[n].es);
            if (tbl[n].es) begin
                d_clr = 1; tick();
                chk("tbl_sat_clr", sat_count, (16'(0)));
            end
        end

        // Commit of a multiply-by-j bank in the middle of a stream.
        d_rs = 1; d_v = 0; tick();
        set_tap(0, 0, 16384, 1'b0);
        d_v = 1; d_xi = 1000; d_xq = 0;
        for (int t = 0; t < 12; t++) begin
            d_commit = (t == 5);
            tick();
        end
        chk("commit_i", Out_I, 0);
        chk("commit_q", Out_Q, 1000);

        // Noise statistics on a zero input.
        d_rs = 1; d_v = 0; tick();
        d_v = 1; d_xi = 0; d_xq = 0; d_sig = 512;
        s_i = 0; s_q = 0; ss_i = 0; ss_q = 0; n_s = 0;
        for (int t = 0; t < 10000; t++) begin
            tick();
            if (out_valid) begin
                s_i += Out_I; s_q += Out_Q;
                ss_i += real'(Out_I) * Out_I; ss_q += real'(Out_Q) * Out_Q;
                n_s++;
            end
        end
        m_i = s_i / n_s; m_q = s_q / n_s;
        chk_rng("noise_mean_i", m_i, -50.0, 50.0);
        chk_rng("noise_mean_q", m_q, -50.0, 50.0);
        chk_rng("noise_std_i", $sqrt(ss_i / n_s - m_i * m_i), 1123.0, 1241.0);
        chk_rng("noise_std_q", $sqrt(ss_q / n_s - m_q * m_q), 1123.0, 1241.0);

        // Randomized traffic: gaps, tap updates, commits, clears, resets.
        d_rs = 1; d_v = 0; tick();
        for (int t = 0; t < 3000; t++) begin
            d_v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                d_xi = ($urandom_range(0, 1) != 0) ? 32000 : -32000;
                d_xq = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                d_xi = int'($urandom_range(0, 8000)) - 4000;
                d_xq = int'($urandom_range(0, 8000)) - 4000;
            end
            d_sig    = int'($urandom_range(0, 2047));
            d_we     = ($urandom_range(0, 7) == 0);
            d_addr   = int'($urandom_range(0, 3));
            d_ci     = int'($urandom_range(0, 65535)) - 32768;
            d_cq     = int'($urandom_range(0, 65535)) - 32768;
            d_commit = ($urandom_range(0, 15) == 0);
            d_clr    = ($urandom_range(0, 63) == 0);
            d_rs     = ($urandom_range(0, 499) == 0);
            tick();
        end
        d_v = 0;
        for (int t = 0; t < 5; t++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
